// File: rtl/ro_meas_pkg.sv
// Shared definitions for the ring-oscillator measurement blocks:
// FSM state encoding, default sizing constants and the window-counter
// width helper.
package ro_meas_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } ro_state_e;

    // Default sizing used when an instance does not override it.
    localparam int unsigned DEF_GATE_CYCLES = 1024;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Width of a counter that must count 0 .. gate_cycles-1.
    // Never narrower than one bit so degenerate sizes still elaborate.
    function automatic int unsigned win_w(input int unsigned gate_cycles);
        if (gate_cycles <= 1) begin
            return 1;
        end
        return $clog2(gate_cycles);
    endfunction

endpackage

// File: rtl/ro_freq_counter_edge_sync.sv
// Brings an asynchronous oscillator signal into the clk domain and produces
// a one-cycle pulse for every rising edge seen after synchronization.
//
// Pulse timing: a level change first captured by the first flop at edge t
// shows up as rise=1 during the cycle that ends with edge t+SYNC_STAGES.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    // sync_q[0] is the metastability-exposed flop, sync_q[SYNC_STAGES-1]
    // is the first one considered safe to use.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the input through the synchronizer chain, then remember the
    // previous synchronized level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A rising edge is "synchronized level high, previous level low".
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter.
//
// Counts synchronized rising edges of ro_in over a fixed window of
// GATE_CYCLES clk cycles and keeps the result for byte-wise readout.
//
// Handshake: start is a single-cycle request sampled on every clk edge.
// It is accepted only in IDLE or DONE; while busy=1 it is ignored and
// never queued. done/overflow are sticky until the next accepted start.
//
// Sequence for a start sampled at edge N:
//   N+1            ARM  (one cycle, absorbs synchronizer latency, no counting)
//   N+2..N+1+G     GATE (G = GATE_CYCLES cycles, rises counted)
//   N+2+G onward   DONE (count_out/overflow/done valid)
// count_out only changes on the GATE->DONE edge, so the previous result
// stays readable while a new measurement runs.
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             start,
    input  logic [1:0]       byte_sel,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] count_out,
    output logic [7:0]       byte_out,
    output ro_state_e        state_dbg
);

    localparam int unsigned      WIN_W    = win_w(GATE_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    ro_state_e        state_q, state_d;

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic             rise;
    logic             accept;
    logic             in_gate;
    logic             gate_last;
    logic             busy_dec;
    logic [31:0]      count_ext;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ro_in),
        .rise     (rise)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ARM is always one cycle, GATE ends on the last
    // window count, IDLE and DONE both wait for start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = ST_GATE;
            end
            ST_GATE: begin
                if (gate_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_ARM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: busy and the datapath strobes derived from state.
    always_comb begin
        busy_dec  = 1'b0;
        accept    = 1'b0;
        in_gate   = 1'b0;
        gate_last = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                accept = start;
            end
            ST_ARM: begin
                busy_dec = 1'b1;
            end
            ST_GATE: begin
                busy_dec  = 1'b1;
                in_gate   = 1'b1;
                gate_last = (win_cnt_q == WIN_LAST);
            end
            ST_DONE: begin
                accept = start;
            end
            default: begin
                busy_dec = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and result registers
    // ------------------------------------------------------------------

    // Next-state for window/edge counters and the sticky result flags.
    // The final count is taken from edge_cnt_d so a rise in the last
    // GATE cycle is included in the result.
    always_comb begin
        win_cnt_d  = win_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        count_d    = count_q;
        done_d     = done_q;
        ovf_d      = ovf_q;

        if (accept) begin
            win_cnt_d  = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
            done_d     = 1'b0;
            ovf_d      = 1'b0;
        end else if (in_gate) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (rise) begin
                if (edge_cnt_q == CNT_MAX) begin
                    // Counter pinned at full scale: an edge was lost.
                    sat_d = 1'b1;
                end else begin
                    edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
            end
            if (gate_last) begin
                count_d = edge_cnt_d;
                ovf_d   = sat_d;
                done_d  = 1'b1;
            end
        end
    end

    // Counter and result registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Readout
    // ------------------------------------------------------------------

    // Byte mux over the zero-extended result; bytes beyond CNT_W read 0.
    always_comb begin
        count_ext              = '0;
        count_ext[CNT_W-1:0]   = count_q;
        unique case (byte_sel)
            2'd0:    byte_out = count_ext[7:0];
            2'd1:    byte_out = count_ext[15:8];
            2'd2:    byte_out = count_ext[23:16];
            default: byte_out = count_ext[31:24];
        endcase
    end

    assign busy      = busy_dec;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign count_out = count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter. Three instances cover the basic
// window (A: 64 cycles / 16 bit), saturation (B: 256 cycles / 4 bit) and
// a wider readout value (C: 1100 cycles / 12 bit).
//
// Oscillator stimulus is driven on falling edges as a function of k, the
// rising-edge index relative to the edge that samples start (k = 0).
// A 0->1 change driven before edge k is counted iff 0 <= k <= GATE-1.
module tb_ro_freq_counter;
    import ro_meas_pkg::*;

    logic clk;
    logic rst;
    logic [1:0] byte_sel;

    logic ro_a, ro_b, ro_c;
    logic start_a, start_b, start_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic ovf_a, ovf_b, ovf_c;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [11:0] cnt_c;
    logic [7:0]  byte_a, byte_b, byte_c;
    ro_state_e   st_a, st_b, st_c;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ro_freq_counter #(.GATE_CYCLES(64), .CNT_W(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .ro_in(ro_a), .start(start_a), .byte_sel(byte_sel),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .count_out(cnt_a),
        .byte_out(byte_a), .state_dbg(st_a)
    );

    ro_freq_counter #(.GATE_CYCLES(256), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .ro_in(ro_b), .start(start_b), .byte_sel(byte_sel),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .count_out(cnt_b),
        .byte_out(byte_b), .state_dbg(st_b)
    );

    ro_freq_counter #(.GATE_CYCLES(1100), .CNT_W(12), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .rst(rst), .ro_in(ro_c), .start(start_c), .byte_sel(byte_sel),
        .busy(busy_c), .done(done_c), .overflow(ovf_c), .count_out(cnt_c),
        .byte_out(byte_c), .state_dbg(st_c)
    );

    // ---------------- accessors ----------------
    function automatic logic [31:0] get_cnt(input int which);
        case (which)
            0:       return 32'(cnt_a);
            1:       return 32'(cnt_b);
            default: return 32'(cnt_c);
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic get_done(input int which);
        case (which)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic get_ovf(input int which);
        case (which)
            0:       return ovf_a;
            1:       return ovf_b;
            default: return ovf_c;
        endcase
    endfunction

    function automatic ro_state_e get_state(input int which);
        case (which)
            0:       return st_a;
            1:       return st_b;
            default: return st_c;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input int which);
        case (which)
            0:       return byte_a;
            1:       return byte_b;
            default: return byte_c;
        endcase
    endfunction

    // h == 0: step to 1 at k >= off; h > 0: square wave, half-period h.
    function automatic logic pat(input int h, input int off, input int k);
        if (h == 0) begin
            return logic'(k >= off);
        end
        return logic'(((k + off) / h) % 2 == 1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_ro(input int which, input logic v);
        case (which)
            0:       ro_a = v;
            1:       ro_b = v;
            default: ro_c = v;
        endcase
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    // One measurement on instance `which`, with timing checks along the
    // way. extra_k pulses start again at that k; hold_exp >= 0 checks the
    // previous result is still presented mid-window.
    task automatic drive_run(input int which, input int h, input int off, input int g,
                             input int extra_k, input int hold_exp);
        for (int k = -8; k <= g + 2; k++) begin
            @(negedge clk);
            // Outputs here reflect edge k-1.
            if (k == 1) begin
                vectors++;
                if (get_busy(which) !== 1'b1 || get_done(which) !== 1'b0 ||
                    get_ovf(which) !== 1'b0 || get_state(which) !== ST_ARM) begin
                    miscompares++;
                    $display("FAIL arm_cycle dut%0d: busy=%b done=%b ovf=%b state=%0d, need 1 0 0 %0d",
                             which, get_busy(which), get_done(which), get_ovf(which),
                             get_state(which), ST_ARM);
                end
            end
            if (k == 2) begin
                vectors++;
                if (get_state(which) !== ST_GATE) begin
                    miscompares++;
                    $display("FAIL gate_entry dut%0d: state=%0d, need %0d",
                             which, get_state(which), ST_GATE);
                end
            end
            if (hold_exp >= 0 && k == g / 2) begin
                vectors++;
                if (get_cnt(which) !== 32'(hold_exp)) begin
                    miscompares++;
                    $display("FAIL hold_prev dut%0d: count_out=%0d, need %0d",
                             which, get_cnt(which), hold_exp);
                end
            end
            if (k == g + 1) begin
                vectors++;
                if (get_done(which) !== 1'b0 || get_busy(which) !== 1'b1) begin
                    miscompares++;
                    $display("FAIL last_gate dut%0d: done=%b busy=%b, need 0 1",
                             which, get_done(which), get_busy(which));
                end
            end
            if (k == g + 2) begin
                vectors++;
                if (get_done(which) !== 1'b1 || get_busy(which) !== 1'b0 ||
                    get_state(which) !== ST_DONE) begin
                    miscompares++;
                    $display("FAIL done_edge dut%0d: done=%b busy=%b state=%0d, need 1 0 %0d",
                             which, get_done(which), get_busy(which), get_state(which), ST_DONE);
                end
            end
            set_ro(which, pat(h, off, k));
            set_start(which, (k == 0) || (k == extra_k));
        end
        @(negedge clk);
        set_start(which, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            vectors++;
            if (get_busy(w) !== 1'b0 || get_done(w) !== 1'b0 || get_ovf(w) !== 1'b0 ||
                get_cnt(w) !== 32'd0 || get_state(w) !== ST_IDLE) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: busy=%b done=%b ovf=%b cnt=%0d state=%0d, need all 0",
                         w, get_busy(w), get_done(w), get_ovf(w), get_cnt(w), get_state(w));
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_count();
        // Rises at k = 0,8,..,56 (and 64, outside the window): 8 counted.
        drive_run(0, 4, 12, 64, -100, -1);
        vectors++;
        if (cnt_a !== 16'd8 || done_a !== 1'b1 || ovf_a !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_p8_first dut0: cnt=%0d done=%b ovf=%b, need 8 1 0", cnt_a, done_a, ovf_a);
        end
        // Rises at k = -1 (before window), 7,15,..,63 (last cycle): 8 counted.
        drive_run(0, 4, 5, 64, -100, -1);
        vectors++;
        if (cnt_a !== 16'd8 || done_a !== 1'b1 || ovf_a !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_p8_last dut0: cnt=%0d done=%b ovf=%b, need 8 1 0", cnt_a, done_a, ovf_a);
        end
    endtask

    task automatic test_static();
        drive_run(0, 0, 1000, 64, -100, -1);
        vectors++;
        if (cnt_a !== 16'd0) begin
            miscompares++;
            $display("FAIL static_low dut0: cnt=%0d, need 0", cnt_a);
        end
        drive_run(0, 0, -1000, 64, -100, -1);
        vectors++;
        if (cnt_a !== 16'd0) begin
            miscompares++;
            $display("FAIL static_high dut0: cnt=%0d, need 0", cnt_a);
        end
        // Step whose pulse lands in the ARM cycle: not counted.
        drive_run(0, 0, -1, 64, -100, -1);
        vectors++;
        if (cnt_a !== 16'd0) begin
            miscompares++;
            $display("FAIL step_in_arm dut0: cnt=%0d, need 0", cnt_a);
        end
        // Step whose pulse lands in the first GATE cycle: counted once.
        drive_run(0, 0, 0, 64, -100, -1);
        vectors++;
        if (cnt_a !== 16'd1) begin
            miscompares++;
            $display("FAIL step_first_gate dut0: cnt=%0d, need 1", cnt_a);
        end
    endtask

    task automatic test_start_while_busy();
        // Extra start at k=12 (GATE cycle 10) must be ignored.
        drive_run(0, 4, 12, 64, 12, 1);
        vectors++;
        if (cnt_a !== 16'd8 || done_a !== 1'b1) begin
            miscompares++;
            $display("FAIL start_busy dut0: cnt=%0d done=%b, need 8 1", cnt_a, done_a);
        end
        // New run from DONE: 8 held during the run, 0 afterwards.
        drive_run(0, 0, 1000, 64, -100, 8);
        vectors++;
        if (cnt_a !== 16'd0 || done_a !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_from_done dut0: cnt=%0d done=%b, need 0 1", cnt_a, done_a);
        end
    endtask

    task automatic test_saturation();
        // Rises at k%4 == 2 over 256 cycles: 64 edges into a 4-bit counter.
        drive_run(1, 2, 8, 256, -100, -1);
        vectors++;
        if (cnt_b !== 4'd15 || ovf_b !== 1'b1 || done_b !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate dut1: cnt=%0d ovf=%b done=%b, need 15 1 1", cnt_b, ovf_b, done_b);
        end
        vectors++;
        if (byte_sel !== 2'd0 || byte_b !== 8'h0F) begin
            miscompares++;
            $display("FAIL sat_byte0 dut1: byte=%h, need 0f", byte_b);
        end
        byte_sel = 2'd1;
        #1;
        vectors++;
        if (byte_b !== 8'h00) begin
            miscompares++;
            $display("FAIL sat_byte1 dut1: byte=%h, need 00", byte_b);
        end
        byte_sel = 2'd0;
        // Next run: flags clear one cycle after start (checked at k=1),
        // 15 is held mid-run, and a quiet input then gives 0.
        drive_run(1, 0, 1000, 256, -100, 15);
        vectors++;
        if (cnt_b !== 4'd0 || ovf_b !== 1'b0) begin
            miscompares++;
            $display("FAIL after_sat dut1: cnt=%0d ovf=%b, need 0 0", cnt_b, ovf_b);
        end
    endtask

    task automatic test_reset_mid_gate();
        drive_run(0, 4, 12, 64, -100, -1);
        for (int k = -8; k < 33; k++) begin
            @(negedge clk);
            set_ro(0, pat(4, 12, k));
            set_start(0, k == 0);
        end
        @(negedge clk);
        vectors++;
        if (busy_a !== 1'b1 || cnt_a !== 16'd8) begin
            miscompares++;
            $display("FAIL pre_reset dut0: busy=%b cnt=%0d, need 1 8", busy_a, cnt_a);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || ovf_a !== 1'b0 ||
            cnt_a !== 16'd0 || byte_a !== 8'h00 || st_a !== ST_IDLE) begin
            miscompares++;
            $display("FAIL async_reset dut0: busy=%b done=%b ovf=%b cnt=%0d byte=%h state=%0d, need all 0",
                     busy_a, done_a, ovf_a, cnt_a, byte_a, st_a);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        drive_run(0, 4, 12, 64, -100, 0);
        vectors++;
        if (cnt_a !== 16'd8 || done_a !== 1'b1 || ovf_a !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_run dut0: cnt=%0d done=%b ovf=%b, need 8 1 0", cnt_a, done_a, ovf_a);
        end
    endtask

    task automatic test_readout();
        logic [7:0] exp_c [4];
        logic [7:0] exp_a [4];
        // 1100 cycles, rise every 4: 275 = 12'h113.
        drive_run(2, 2, 8, 1100, -100, -1);
        vectors++;
        if (cnt_c !== 12'h113 || ovf_c !== 1'b0) begin
            miscompares++;
            $display("FAIL wide_count dut2: cnt=%h ovf=%b, need 113 0", cnt_c, ovf_c);
        end
        exp_c = '{8'h13, 8'h01, 8'h00, 8'h00};
        exp_a = '{8'h08, 8'h00, 8'h00, 8'h00};
        for (int s = 0; s < 4; s++) begin
            byte_sel = 2'(s);
            #1;
            vectors++;
            if (byte_c !== exp_c[s] || byte_a !== exp_a[s]) begin
                miscompares++;
                $display("FAIL readout sel=%0d: dut2=%h dut0=%h, need %h %h",
                         s, byte_c, byte_a, exp_c[s], exp_a[s]);
            end
        end
        byte_sel = 2'd0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        byte_sel = 2'd0;
        ro_a = 1'b0; ro_b = 1'b0; ro_c = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        test_reset();
        test_basic_count();
        test_static();
        test_start_while_busy();
        test_saturation();
        test_reset_mid_gate();
        test_readout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
